// File: rtl/ahb_resp_mux_router.sv
// AHB data-phase response router: steers the owning slave's response to the owning master, with a built-in ERROR default slave.
// Optional wait-state timeout enabled by defining AHB_RESP_TIMEOUT_EN.
module ahb_resp_mux_router #(
  parameter int NUM_SLAVES     = 4,
  parameter int NUM_MASTERS    = 2,
  parameter int DATA_WIDTH     = 32,
  parameter logic [DATA_WIDTH-1:0] DEFAULT_RDATA = 32'hDEADBEEF,
  parameter int TIMEOUT_CYCLES = 16,
  localparam int MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                  Hclk,
  input  logic                  Hresetn,
  input  logic [NUM_SLAVES-1:0] Hsel,
  input  logic [MW-1:0]         Hmaster,
  input  logic [1:0]            Htrans,
  input  logic [DATA_WIDTH-1:0] Hrdata_S [NUM_SLAVES],
  input  logic [1:0]            Hresp_S [NUM_SLAVES],
  input  logic                  Hreadyout_S [NUM_SLAVES],
  output logic [DATA_WIDTH-1:0] Hrdata [NUM_MASTERS],
  output logic [1:0]            Hresp [NUM_MASTERS],
  output logic                  Hready,
  output logic                  Htimeout
);

  localparam int SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ERR1 = 2'd1,
    ST_ERR2 = 2'd2
  } state_t;

  state_t                  state_r, state_s;
  logic [NUM_SLAVES-1:0]   sel_r;
  logic [MW-1:0]           master_r;
  logic                    active_r;
  logic [SW-1:0]           sel_idx_s;
  logic                    map_ok_s;
  logic                    addr_unmapped_s;
  logic                    hready_s;
  logic [DATA_WIDTH-1:0]   rdata_s;
  logic [1:0]              resp_s;
  logic                    tmo_hit_s;

  // Non-one-hot selects resolve to the lowest set bit.
  function automatic logic [SW-1:0] lowest_idx(input logic [NUM_SLAVES-1:0] v);
    logic [SW-1:0] idx;
    idx = {SW{1'b0}};
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (v[i]) idx = SW'(i);
    end
    return idx;
  endfunction

  function automatic logic master_ok(input logic [MW-1:0] m);
    return (32'(m) < 32'(NUM_MASTERS));
  endfunction

  assign sel_idx_s       = lowest_idx(sel_r);
  assign map_ok_s        = active_r && (sel_r != {NUM_SLAVES{1'b0}}) && master_ok(master_r);
  assign addr_unmapped_s = Htrans[1] && ((Hsel == {NUM_SLAVES{1'b0}}) || !master_ok(Hmaster));

  // Response selection for the master owning the current data phase.
  always_comb begin
    hready_s = 1'b1;
    resp_s   = 2'b00;
    rdata_s  = DEFAULT_RDATA;
    if (state_r == ST_ERR1) begin
      hready_s = 1'b0;
      resp_s   = 2'b01;
    end else if (state_r == ST_ERR2) begin
      hready_s = 1'b1;
      resp_s   = 2'b01;
    end else if (map_ok_s) begin
      hready_s = Hreadyout_S[sel_idx_s];
      resp_s   = Hresp_S[sel_idx_s];
      rdata_s  = Hrdata_S[sel_idx_s];
    end else begin
      hready_s = 1'b1;
    end
  end

  // Fan the selected response out to the owning master only.
  always_comb begin
    for (int m = 0; m < NUM_MASTERS; m++) begin
      if (32'(master_r) == 32'(m)) begin
        Hrdata[m] = rdata_s;
        Hresp[m]  = resp_s;
      end else begin
        Hrdata[m] = DEFAULT_RDATA;
        Hresp[m]  = 2'b00;
      end
    end
  end

  assign Hready = hready_s;

  // Default-slave / timeout FSM next state; an unmapped capture enters ERR1 directly.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_ERR1: state_s = ST_ERR2;
      ST_IDLE, ST_ERR2: begin
        if (hready_s) state_s = addr_unmapped_s ? ST_ERR1 : ST_IDLE;
        else if (tmo_hit_s) state_s = ST_ERR1;
        else state_s = state_r;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Address-phase capture and FSM state register.
  always_ff @(posedge Hclk or posedge Hresetn) begin
    if (Hresetn) begin
      state_r  <= ST_IDLE;
      sel_r    <= {NUM_SLAVES{1'b0}};
      master_r <= {MW{1'b0}};
      active_r <= 1'b0;
    end else begin
      state_r <= state_s;
      if (hready_s) begin
        sel_r    <= Hsel;
        master_r <= Hmaster;
        active_r <= Htrans[1];
      end
    end
  end

`ifdef AHB_RESP_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] tmo_cnt_r;
  logic          htimeout_r;
  logic          stall_s;

  assign stall_s   = (state_r == ST_IDLE) && map_ok_s && !Hreadyout_S[sel_idx_s];
  assign tmo_hit_s = stall_s && (tmo_cnt_r == CW'(TIMEOUT_CYCLES - 1));

  // Wait-state counter; the pulse lines up with the first forced ERROR cycle.
  always_ff @(posedge Hclk or posedge Hresetn) begin
    if (Hresetn) begin
      tmo_cnt_r  <= {CW{1'b0}};
      htimeout_r <= 1'b0;
    end else begin
      htimeout_r <= tmo_hit_s;
      if (hready_s) tmo_cnt_r <= {CW{1'b0}};
      else if (stall_s) tmo_cnt_r <= tmo_cnt_r + CW'(1);
    end
  end

  assign Htimeout = htimeout_r;
`else
  assign tmo_hit_s = 1'b0;
  assign Htimeout  = (TIMEOUT_CYCLES < 2) & 1'b0;
`endif

endmodule

// File: tb/tb_ahb_resp_mux_router.sv
// Randomized plus directed bench for ahb_resp_mux_router against a transfer-level reference model.
module tb_ahb_resp_mux_router;
  localparam int NS = 4;
  localparam int NM = 2;
  localparam int DW = 32;
  localparam logic [DW-1:0] DEF = 32'hDEADBEEF;
`ifdef AHB_RESP_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 16;
`endif

  logic          Hclk = 1'b0;
  logic          Hresetn;
  logic [NS-1:0] Hsel;
  logic [0:0]    Hmaster;
  logic [1:0]    Htrans;
  logic [DW-1:0] Hrdata_S [NS];
  logic [1:0]    Hresp_S [NS];
  logic          Hreadyout_S [NS];
  logic [DW-1:0] Hrdata [NM];
  logic [1:0]    Hresp [NM];
  logic          Hready;
  logic          Htimeout;

  ahb_resp_mux_router #(
    .NUM_SLAVES(NS), .NUM_MASTERS(NM), .DATA_WIDTH(DW),
    .DEFAULT_RDATA(DEF), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .Hclk(Hclk), .Hresetn(Hresetn), .Hsel(Hsel), .Hmaster(Hmaster), .Htrans(Htrans),
    .Hrdata_S(Hrdata_S), .Hresp_S(Hresp_S), .Hreadyout_S(Hreadyout_S),
    .Hrdata(Hrdata), .Hresp(Hresp), .Hready(Hready), .Htimeout(Htimeout)
  );

  always #5 Hclk = ~Hclk;

  int checks = 0;
  int failures = 0;

  // Reference model: the transfer in its data phase and how many ERROR cycles it still owes.
  logic          m_active;
  logic [NS-1:0] m_sel;
  int            m_master;
  int            m_err;
  int            m_wait;
  logic          m_tmo_pend;
  logic          m_exp_ready;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic int lowest_bit(input logic [NS-1:0] v);
    for (int i = 0; i < NS; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_active = 1'b0; m_sel = '0; m_master = 0; m_err = 0; m_wait = 0;
    m_tmo_pend = 1'b0; m_exp_ready = 1'b1;
  endtask

  task automatic check_outputs();
    logic          e_ready;
    logic [DW-1:0] e_rd;
    logic [1:0]    e_rs;
    int            i;
    e_ready = 1'b1; e_rd = DEF; e_rs = 2'b00;
    if (m_err == 1) begin
      e_ready = 1'b0; e_rs = 2'b01;
    end else if (m_err == 2) begin
      e_rs = 2'b01;
    end else if (m_active && m_sel != '0) begin
      i = lowest_bit(m_sel);
      e_rd = Hrdata_S[i]; e_rs = Hresp_S[i]; e_ready = Hreadyout_S[i];
    end
    chk("hready", 64'(Hready), 64'(e_ready));
    for (int m = 0; m < NM; m++) begin
      chk($sformatf("hrdata%0d", m), 64'(Hrdata[m]), 64'((m == m_master) ? e_rd : DEF));
      chk($sformatf("hresp%0d", m), 64'(Hresp[m]), 64'((m == m_master) ? e_rs : 2'b00));
    end
    chk("htimeout", 64'(Htimeout), 64'(m_tmo_pend));
    m_exp_ready = e_ready;
  endtask

  task automatic model_edge();
    m_tmo_pend = 1'b0;
    if (m_exp_ready) begin
      m_active = Htrans[1]; m_sel = Hsel; m_master = int'(Hmaster);
      m_err = (Htrans[1] && Hsel == '0) ? 1 : 0;
      m_wait = 0;
    end else if (m_err == 1) begin
      m_err = 2;
    end else begin
      m_wait++;
`ifdef AHB_RESP_TIMEOUT_EN
      if (m_wait == TMO) begin
        m_err = 1; m_tmo_pend = 1'b1;
      end
`endif
    end
  endtask

  task automatic finish_cycle();
    check_outputs();
    @(posedge Hclk);
    model_edge();
    #1;
  endtask

  task automatic cycle();
    @(negedge Hclk);
    finish_cycle();
  endtask

  task automatic slaves_ready();
    for (int s = 0; s < NS; s++) begin
      Hrdata_S[s] = $urandom; Hresp_S[s] = 2'b00; Hreadyout_S[s] = 1'b1;
    end
  endtask

  task automatic rand_inputs();
    int r;
    r = $urandom_range(0, 3);
    if (r == 0) Hsel = '0;
    else if (r == 3) Hsel = NS'($urandom_range(0, 15));
    else Hsel = NS'(1) << $urandom_range(0, NS - 1);
    Htrans  = 2'($urandom_range(0, 3));
    Hmaster = 1'($urandom_range(0, 1));
    for (int s = 0; s < NS; s++) begin
      Hrdata_S[s]    = $urandom;
      Hresp_S[s]     = ($urandom_range(0, 3) == 0) ? 2'b01 : 2'b00;
      Hreadyout_S[s] = ($urandom_range(0, 3) != 0);
    end
  endtask

  initial begin
    logic [DW-1:0] probe;
    Hresetn = 1'b1; Hsel = '0; Hmaster = 1'b0; Htrans = 2'b00;
    slaves_ready();
    model_reset();
    repeat (2) @(posedge Hclk);
    @(negedge Hclk);
    chk("rst_hready", 64'(Hready), 64'(1'b1));
    chk("rst_hresp0", 64'(Hresp[0]), 64'(2'b00));
    chk("rst_hrdata1", 64'(Hrdata[1]), 64'(DEF));
    @(posedge Hclk); #1;
    Hresetn = 1'b0;

    // Routed read: slave 1 to master 1.
    Hsel = 4'b0010; Hmaster = 1'b1; Htrans = 2'b10;
    cycle();
    Htrans = 2'b00; Hsel = '0; Hmaster = 1'b0;
    Hrdata_S[1] = 32'h12345678; Hresp_S[1] = 2'b00; Hreadyout_S[1] = 1'b1;
    @(negedge Hclk);
    chk("route_rdata1", 64'(Hrdata[1]), 64'(32'h12345678));
    chk("route_resp1", 64'(Hresp[1]), 64'(2'b00));
    chk("route_rdata0", 64'(Hrdata[0]), 64'(DEF));
    finish_cycle();

    // Wait states on slave 3; the next address phase must not be taken early.
    Hsel = 4'b1000; Hmaster = 1'b0; Htrans = 2'b10;
    cycle();
    Hreadyout_S[3] = 1'b0; Hsel = 4'b0001; Hmaster = 1'b1; Htrans = 2'b10;
    for (int k = 0; k < 3; k++) begin
      @(negedge Hclk);
      chk("wait_hready", 64'(Hready), 64'(1'b0));
      finish_cycle();
    end
    Hreadyout_S[3] = 1'b1;
    cycle();
    Htrans = 2'b00; Hsel = '0; probe = 32'hA5A50F0F; Hrdata_S[0] = probe;
    @(negedge Hclk);
    chk("wait_capture", 64'(Hrdata[1]), 64'(probe));
    finish_cycle();

    // Unmapped back-to-back: ready 0,1,0,1 with ERROR throughout.
    Hsel = '0; Hmaster = 1'b0; Htrans = 2'b10;
    cycle();
    for (int k = 0; k < 4; k++) begin
      @(negedge Hclk);
      chk("unmap_hready", 64'(Hready), 64'(k % 2));
      chk("unmap_hresp", 64'(Hresp[0]), 64'(2'b01));
      finish_cycle();
      if (k == 1) Htrans = 2'b00;
    end

    // IDLE transfer must not route slave 2.
    Hsel = 4'b0100; Hmaster = 1'b0; Htrans = 2'b00;
    Hrdata_S[2] = 32'hAAAA5555; Hresp_S[2] = 2'b01;
    cycle();
    @(negedge Hclk);
    chk("idle_hready", 64'(Hready), 64'(1'b1));
    chk("idle_hresp", 64'(Hresp[0]), 64'(2'b00));
    chk("idle_hrdata", 64'(Hrdata[0]), 64'(DEF));
    finish_cycle();
    Hresp_S[2] = 2'b00;

`ifdef AHB_RESP_TIMEOUT_EN
    // Slave 0 stalls forever: forced ERROR after TMO wait cycles.
    Hsel = 4'b0001; Hmaster = 1'b0; Htrans = 2'b10;
    cycle();
    Hreadyout_S[0] = 1'b0; Htrans = 2'b00; Hsel = '0;
    for (int k = 0; k < TMO; k++) begin
      @(negedge Hclk);
      chk("tmo_wait", 64'({Hready, Htimeout}), 64'(2'b00));
      finish_cycle();
    end
    @(negedge Hclk);
    chk("tmo_err1", 64'({Htimeout, Hready, Hresp[0]}), 64'(4'b1001));
    finish_cycle();
    @(negedge Hclk);
    chk("tmo_err2", 64'({Htimeout, Hready, Hresp[0]}), 64'(4'b0101));
    finish_cycle();
    Hreadyout_S[0] = 1'b1;
    cycle();
`endif

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      rand_inputs();
      cycle();
    end

    // Reset mid data phase while slave 2 stalls.
    slaves_ready();
    Hsel = 4'b0100; Hmaster = 1'b1; Htrans = 2'b10;
    cycle();
    Hreadyout_S[2] = 1'b0; Htrans = 2'b00;
    @(negedge Hclk);
    chk("pre_rst_hready", 64'(Hready), 64'(1'b0));
    #2 Hresetn = 1'b1;
    #1;
    chk("mid_rst_hready", 64'(Hready), 64'(1'b1));
    for (int m = 0; m < NM; m++) begin
      chk($sformatf("mid_rst_hresp%0d", m), 64'(Hresp[m]), 64'(2'b00));
      chk($sformatf("mid_rst_hrdata%0d", m), 64'(Hrdata[m]), 64'(DEF));
    end
    model_reset();
    @(posedge Hclk); #1;
    Hresetn = 1'b0;
    for (int k = 0; k < 100; k++) begin
      rand_inputs();
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
